// File: rtl/dpsk_rx_deframer.sv
// DBPSK receive deframer: differential decode, sync-word hunt, length byte,
// then payload bytes on a one-entry valid/ready output register.
module dpsk_rx_deframer #(
  parameter logic [15:0] SYNC_WORD = 16'hD391
) (
  input  logic       clk,
  input  logic       r,
  input  logic       sym_valid,
  input  logic       sym_phase,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       locked,
  output logic       ovf,
  output logic       err,
  output logic [1:0] state_dbg
);

  // Output handshake: a byte transfers on every cycle where out_valid && out_ready.
  // out_valid stays high, with out_data/out_last stable, until that cycle.

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        prev_phase;
  logic [15:0] sr;
  logic [7:0]  len;
  logic [7:0]  bcnt;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;

  logic        dbit;
  logic [15:0] sr_next;
  logic [7:0]  byte_next;
  logic        sync_hit;
  logic        len_done;
  logic        byte_done;
  logic        byte_last;
  logic        load_out;

  always_comb begin
    dbit      = sym_phase ^ prev_phase;
    sr_next   = {sr[14:0], dbit};
    byte_next = {shreg[6:0], dbit};
    sync_hit  = sym_valid && (state == HUNT) && (sr_next == SYNC_WORD);
    len_done  = sym_valid && (state == LEN) && (bit_cnt == 3'd7);
    byte_done = sym_valid && (state == PAYLOAD) && (bit_cnt == 3'd7);
    byte_last = (bcnt + 8'd1) == len;
    load_out  = !out_valid || out_ready;

    state_next = state;
    case (state)
      HUNT:    if (sync_hit) state_next = LEN;
      LEN:     if (len_done) state_next = (byte_next == 8'd0) ? HUNT : PAYLOAD;
      PAYLOAD: if (byte_done && byte_last) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state      <= HUNT;
      prev_phase <= 1'b0;
      sr         <= 16'd0;
      len        <= 8'd0;
      bcnt       <= 8'd0;
      shreg      <= 8'd0;
      bit_cnt    <= 3'd0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      ovf   <= 1'b0;
      err   <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (sym_valid) begin
        prev_phase <= sym_phase;
        case (state)
          HUNT: begin
            sr <= sr_next;
            if (sync_hit) bit_cnt <= 3'd0;
          end
          LEN: begin
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (len_done) begin
              if (byte_next == 8'd0) begin
                err <= 1'b1;
                sr  <= 16'd0;
              end else begin
                len  <= byte_next;
                bcnt <= 8'd0;
              end
            end
          end
          PAYLOAD: begin
            shreg   <= byte_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              bcnt <= bcnt + 8'd1;
              // A full output register with no accept this cycle loses the new byte.
              if (load_out) begin
                out_data  <= byte_next;
                out_last  <= byte_last;
                out_valid <= 1'b1;
              end else begin
                ovf <= 1'b1;
              end
              if (byte_last) sr <= 16'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign locked    = (state == LEN) || (state == PAYLOAD);
  assign state_dbg = state;

endmodule

// File: tb/tb_dpsk_rx_deframer.sv
// Self-checking bench for dpsk_rx_deframer: directed timing checks plus a
// bit-stream parsing reference model compared against every accepted byte.
module tb_dpsk_rx_deframer;

  localparam logic [15:0] SYNC = 16'hD391;

  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic       sym_valid = 1'b0;
  logic       sym_phase = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       locked;
  logic       ovf;
  logic       err;
  logic [1:0] state_dbg;

  int checks = 0;
  int passes = 0;

  logic       tb_prev;
  bit         sent_bits[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         exp_err;
  int         ovf_cnt, err_cnt, last_cnt;

  dpsk_rx_deframer #(.SYNC_WORD(SYNC)) dut (
    .clk(clk), .r(r), .sym_valid(sym_valid), .sym_phase(sym_phase),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .locked(locked), .ovf(ovf), .err(err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor: record accepted bytes and pulse counts
  always @(negedge clk) begin
    if (!r) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (ovf) ovf_cnt++;
      if (err) err_cnt++;
      if (out_valid && out_last) last_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int cyc);
    r = 1'b1;
    repeat (cyc) begin
      sym_valid = 1'($urandom_range(0, 1));
      sym_phase = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    r = 1'b0;
    sym_valid = 1'b0;
    sym_phase = 1'b0;
    tb_prev = 1'b0;
    sent_bits.delete();
    got_q.delete();
    exp_q.delete();
    ovf_cnt = 0; err_cnt = 0; last_cnt = 0;
  endtask

  // driver: one strobe carrying a raw phase, after 'gap' idle cycles
  task automatic send_phase(input logic ph, input int gap);
    idle(gap);
    sym_valid = 1'b1;
    sym_phase = ph;
    @(posedge clk); #1;
    sym_valid = 1'b0;
    sym_phase = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b, input int gap);
    logic ph;
    ph = tb_prev ^ b;
    tb_prev = ph;
    sent_bits.push_back(b);
    send_phase(ph, gap);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_byte_but_last(input logic [7:0] v);
    for (int i = 7; i >= 1; i--) send_bit(v[i], 0);
  endtask

  task automatic send_garbage(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 0);
  endtask

  // reference model: parse the whole transmitted bit stream into expected bytes
  task automatic run_model();
    int n, i;
    logic [15:0] win;
    logic [7:0] l, b;
    exp_q.delete();
    exp_err = 0;
    n = sent_bits.size();
    i = 0;
    win = 16'd0;
    while (i < n) begin
      win = {win[14:0], sent_bits[i]};
      i++;
      if (win == SYNC) begin
        win = 16'd0;
        if (i + 8 > n) break;
        l = 8'd0;
        for (int k = 0; k < 8; k++) l = {l[6:0], sent_bits[i + k]};
        i += 8;
        if (l == 8'd0) begin
          exp_err++;
          continue;
        end
        for (int j = 0; j < int'(l); j++) begin
          if (i + 8 > n) begin
            i = n;
            break;
          end
          b = 8'd0;
          for (int k = 0; k < 8; k++) b = {b[6:0], sent_bits[i + k]};
          i += 8;
          exp_q.push_back({(j == int'(l) - 1), b});
        end
      end
    end
  endtask

  task automatic check_scoreboard(input string name);
    int m;
    run_model();
    checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL %s byte count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    else passes++;
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s byte %0d {last,data}: got %h expected %h", name, i, got_q[i], exp_q[i]);
      else passes++;
    end
    checks++;
    if (err_cnt !== exp_err)
      $display("FAIL %s err pulses: got %0d expected %0d", name, err_cnt, exp_err);
    else passes++;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset out_data: got %h expected 00", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset out_last: got %b expected 0", out_last); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL reset locked: got %b expected 0", locked); else passes++;
    checks++; if (ovf !== 1'b0) $display("FAIL reset ovf: got %b expected 0", ovf); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset err: got %b expected 0", err); else passes++;
    send_phase(1'b1, 0);
    checks++; if (dut.sr !== 16'h0001) $display("FAIL reset first symbol sr: got %h expected 0001", dut.sr); else passes++;
  endtask

  task automatic test_decode();
    logic ph_list [5];
    logic [15:0] exp_sr;
    logic p, b;
    ph_list = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(2);
    exp_sr = 16'd0;
    p = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = ph_list[i] ^ p;
      p = ph_list[i];
      exp_sr = {exp_sr[14:0], b};
      send_phase(ph_list[i], $urandom_range(0, 2));
      checks++;
      if (dut.sr !== exp_sr) $display("FAIL decode step %0d sr: got %h expected %h", i, dut.sr, exp_sr); else passes++;
    end
    checks++; if (dut.sr !== 16'h000A) $display("FAIL decode final sr: got %h expected 000a", dut.sr); else passes++;
  endtask

  task automatic test_frame_ready();
    do_reset(2);
    out_ready = 1'b1;
    send_garbage(5);
    send_byte(8'hD3, 0);
    send_byte_but_last(8'h91);
    checks++; if (locked !== 1'b0) $display("FAIL frame locked before sync end: got %b expected 0", locked); else passes++;
    send_bit(1'b1, 0);
    checks++; if (locked !== 1'b1) $display("FAIL frame locked after sync: got %b expected 1", locked); else passes++;
    send_byte(8'h02, 0);
    send_byte_but_last(8'hA5);
    send_bit(1'b1, 0);
    checks++; if (out_valid !== 1'b1) $display("FAIL frame A5 out_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'hA5) $display("FAIL frame A5 out_data: got %h expected a5", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL frame A5 out_last: got %b expected 0", out_last); else passes++;
    checks++; if (locked !== 1'b1) $display("FAIL frame locked mid payload: got %b expected 1", locked); else passes++;
    send_byte_but_last(8'h3C);
    send_bit(1'b0, 0);
    checks++; if (out_valid !== 1'b1) $display("FAIL frame 3C out_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h3C) $display("FAIL frame 3C out_data: got %h expected 3c", out_data); else passes++;
    checks++; if (out_last !== 1'b1) $display("FAIL frame 3C out_last: got %b expected 1", out_last); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL frame locked after end: got %b expected 0", locked); else passes++;
    idle(3);
    check_scoreboard("frame_ready");
  endtask

  task automatic test_backpressure();
    do_reset(2);
    out_ready = 1'b0;
    send_garbage(5);
    send_byte(8'hD3, 0);
    send_byte(8'h91, 0);
    send_byte(8'h02, 0);
    send_byte(8'hA5, 0);
    checks++; if (out_valid !== 1'b1) $display("FAIL bp A5 out_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'hA5) $display("FAIL bp A5 out_data: got %h expected a5", out_data); else passes++;
    send_byte(8'h3C, 0);
    checks++; if (ovf !== 1'b1) $display("FAIL bp ovf at drop: got %b expected 1", ovf); else passes++;
    checks++; if (out_data !== 8'hA5) $display("FAIL bp held out_data: got %h expected a5", out_data); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL bp held out_last: got %b expected 0", out_last); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL bp locked after drop: got %b expected 0", locked); else passes++;
    idle(1);
    checks++; if (ovf !== 1'b0) $display("FAIL bp ovf width: got %b expected 0", ovf); else passes++;
    out_ready = 1'b1;
    idle(1);
    checks++; if (out_valid !== 1'b0) $display("FAIL bp out_valid after accept: got %b expected 0", out_valid); else passes++;
    checks++; if (ovf_cnt !== 1) $display("FAIL bp ovf pulses: got %0d expected 1", ovf_cnt); else passes++;
    checks++; if (last_cnt !== 0) $display("FAIL bp out_last cycles: got %0d expected 0", last_cnt); else passes++;
    checks++; if (got_q.size() !== 1) $display("FAIL bp accepted count: got %0d expected 1", got_q.size()); else passes++;
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 9'h0A5) $display("FAIL bp accepted byte: got %h expected 0a5", got_q[0]); else passes++;
    end
  endtask

  task automatic test_zero_len();
    do_reset(2);
    out_ready = 1'b1;
    send_byte(8'hD3, 0);
    send_byte(8'h91, 0);
    send_byte(8'h00, 0);
    checks++; if (err !== 1'b1) $display("FAIL zlen err: got %b expected 1", err); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL zlen locked: got %b expected 0", locked); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL zlen out_valid: got %b expected 0", out_valid); else passes++;
    idle(1);
    checks++; if (err !== 1'b0) $display("FAIL zlen err width: got %b expected 0", err); else passes++;
    send_byte(8'hD3, 0);
    send_byte(8'h91, 0);
    send_byte(8'h01, 0);
    send_byte(8'h7E, 0);
    checks++; if (out_data !== 8'h7E) $display("FAIL zlen next out_data: got %h expected 7e", out_data); else passes++;
    checks++; if (out_last !== 1'b1) $display("FAIL zlen next out_last: got %b expected 1", out_last); else passes++;
    idle(3);
    checks++; if (err_cnt !== 1) $display("FAIL zlen err pulses: got %0d expected 1", err_cnt); else passes++;
    check_scoreboard("zero_len");
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    out_ready = 1'b1;
    send_byte(8'hD3, 0);
    send_byte(8'h91, 0);
    send_byte(8'h03, 0);
    send_garbage(4);
    do_reset(1);
    checks++; if (locked !== 1'b0) $display("FAIL rmid locked: got %b expected 0", locked); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rmid out_valid: got %b expected 0", out_valid); else passes++;
    out_ready = 1'b1;
    send_byte(8'hD3, 0);
    send_byte(8'h91, 0);
    send_byte(8'h02, 0);
    send_byte(8'($urandom_range(0, 255)), 0);
    send_byte(8'($urandom_range(0, 255)), 0);
    idle(3);
    check_scoreboard("reset_mid");
  endtask

  task automatic test_back_to_back();
    int l;
    do_reset(2);
    out_ready = 1'b1;
    for (int f = 0; f < 7; f++) begin
      int gap;
      gap = (f % 2 == 1) ? 1 : 0;
      l = (f == 0) ? 255 : $urandom_range(1, 5);
      if (f >= 3) send_garbage($urandom_range(0, 6));
      send_byte(8'hD3, gap);
      send_byte(8'h91, gap);
      send_byte(8'(l), gap);
      for (int j = 0; j < l; j++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, gap * 2));
    end
    idle(3);
    checks++; if (ovf_cnt !== 0) $display("FAIL b2b ovf pulses: got %0d expected 0", ovf_cnt); else passes++;
    check_scoreboard("back_to_back");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_frame_ready();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dpsk_rx_deframer.md
# dpsk_rx_deframer

Receive-side counterpart of the DBPSK transmit framer. It takes hard-decided symbol phases at the symbol strobe and differentially decodes them to bits. It hunts for a 16-bit sync word, reads a length byte, and delivers the payload as bytes on a valid/ready output port. It sits between the symbol slicer and the byte-level consumer. All state registers are synchronous-reset flops from the team flop library.

## Interface
- SYNC_WORD, 16'hD391, frame sync pattern, MSB first; must be nonzero
- clk  input  1  single system clock; all logic on posedge
- r  input  1  synchronous, active-high reset
- sym_valid  input  1  one-cycle strobe; sym_phase is valid this cycle
- sym_phase  input  1  sliced phase: 0 = 0°, 1 = 180°
- out_data  output  8  payload byte, MSB = first received bit
- out_valid  output  1  out_data holds an unaccepted byte
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_last  output  1  qualifies out_data as the final byte of the frame
- locked  output  1  high in states LEN and PAYLOAD
- ovf  output  1  one-cycle pulse: a completed byte was dropped
- err  output  1  one-cycle pulse: length byte was zero

## Operation
- Differential decode, on every sym_valid in every state:
  - bit = sym_phase ^ prev_phase.
  - prev_phase <= sym_phase.
  - prev_phase resets to 0, so the first symbol after reset is decoded against a 0° reference.
- All bit collection is MSB first. No register changes on cycles without sym_valid, except the out_valid handshake.
- States are HUNT (reset state), LEN and PAYLOAD.
- HUNT:
  - sr[15:0] <= {sr[14:0], bit}.
  - When the updated value equals SYNC_WORD, go to LEN and clear the bit counter.
  - sr is cleared on reset and on every entry to HUNT, so sync bits cannot be shared between frames.
- LEN:
  - Collect 8 bits into len.
  - On the 8th bit: if the value is 0, pulse err and go to HUNT. Otherwise store len, clear the byte count bcnt, and go to PAYLOAD.
- PAYLOAD:
  - Collect 8 bits into a shift register. On the 8th bit the byte is complete and bcnt increments.
  - The completed byte is last when bcnt+1 == len (8-bit compare, len range 1..255).
  - After the last byte, go to HUNT whether or not that byte was dropped.
- Output register (one entry):
  - Completion when out_valid == 0, or out_ready == 1 that same cycle: load out_data and out_last, and set out_valid.
  - Completion when out_valid == 1 and out_ready == 0: drop the byte, pulse ovf, leave out_data/out_last unchanged. Frame counting continues.
  - A handshake with no completion that cycle clears out_valid.
- Reset mid-operation: all state returns to reset values immediately, and any partial frame is discarded.

## Timing
- Reset values:
  - Outputs: out_valid = 0, out_data = 0, out_last = 0, locked = 0, ovf = 0, err = 0.
  - Internal: state = HUNT, prev_phase = 0, sr = 0, len = 0, bcnt = 0.
- Sync detect: locked rises the cycle after the sym_valid carrying the final sync bit.
- Byte latency: out_valid rises the cycle after the sym_valid carrying bit 8.
- ovf and err are registered and high for exactly the cycle after the offending sym_valid.
- End of frame: locked falls the cycle after the last payload bit, or after the len = 0 bit. This is the same cycle out_valid rises with out_last.
- Back-to-back: the next frame's sync bits may follow with no idle symbols.
- Symbol strobes may be adjacent (one per clk); no minimum spacing is required.

## Test plan
- Reset: hold r for 2 cycles with random inputs. Required: all outputs 0, and the first symbol after reset with sym_phase = 1 decodes to bit 1.
- Decode: phase stream 0,1,1,0,0 after reset. Required: decoded bits 0,1,0,1,0, checked via sr.
- Frame with out_ready = 1:
  - Stimulus: 5 garbage bits, then bits of D391, len 02, A5, 3C, all encoded differentially.
  - Required: bytes A5 (out_last = 0) then 3C (out_last = 1), each 1 cycle after its 8th symbol; locked high from after D391 to after 3C.
- Backpressure: same frame with out_ready = 0. Required: out_data = A5 stays valid, ovf pulses once at the 3C completion, and no out_last is seen. Then raise out_ready: out_valid drops the next cycle.
- Zero length: D391 followed by len 00. Required: err pulses once, locked drops, and no out_valid. A following D391/01/7E frame delivers 7E with out_last = 1.
- Reset mid-payload: assert r after 4 bits of the first payload byte. Required: locked = 0 and no output. A full subsequent frame then decodes correctly against the 0° reference.
